serial_rx_controller: RTL and testbench
=======================================

SERIAL_RX_CONTROLLER -- requirements
Module: serial_rx_controller

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of FIFO entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 2000, SHALL set the maximum clock-cycle gap between payload words.
REQ-003 Parameter SYNC, default 4'hA, SHALL set the required header sync nibble.
REQ-004 Clock  input  1  sole clock; all state changes on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 RxValid  input  1  one-cycle strobe from the serial receiver: RxData holds a new word.
REQ-007 RxData  input  16  received word.
REQ-008 Ready  input  1  consumer accepts WordOut this cycle.
REQ-009 ClearErr  input  1  clears all sticky error flags.
REQ-010 WordValid  output  1  FIFO non-empty; WordOut/First/Last are valid.
REQ-011 WordOut  output  16  head-of-FIFO payload word.
REQ-012 First  output  1  head word is first payload word of its packet.
REQ-013 Last  output  1  head word is last payload word of its packet.
REQ-014 Busy  output  1  high while state is PAYLOAD.
REQ-015 Overflow, SyncErr, LenErr, TimeoutErr  output  1 each  sticky error flags.

Function
REQ-016 The FSM SHALL have two states: IDLE (awaiting header) and PAYLOAD (counting payload words).
REQ-017 In IDLE, on RxValid, RxData[15:12]==SYNC with RxData[3:0]!=0 SHALL load Remaining<=RxData[3:0] and go to PAYLOAD; the header is never written to the FIFO.
REQ-018 In IDLE, on RxValid, a sync mismatch SHALL set SyncErr; sync match with length 0 SHALL set LenErr; the FSM stays IDLE in both cases.
REQ-019 In PAYLOAD, each RxValid SHALL push {RxData, First, Last} into the FIFO, with First=1 for the first payload word and Last=1 when Remaining==1, then decrement Remaining.
REQ-020 On the word with Remaining==1, the FSM SHALL return to IDLE in the same cycle as the push.
REQ-021 A push while the FIFO is full and no pop occurs that cycle SHALL drop the word and set Overflow; Remaining still decrements so framing stays aligned.
REQ-022 A push while full with simultaneous pop (WordValid && Ready) SHALL be accepted.
REQ-023 Pop SHALL occur when WordValid && Ready; the FIFO read pointer SHALL advance by one, with no change when empty.
REQ-024 A word pushed into an empty FIFO SHALL appear on WordOut one cycle later; there is no bypass path.
REQ-025 A 16-bit gap counter SHALL reset to 0 on entering PAYLOAD and on every RxValid, and increment each cycle in PAYLOAD otherwise.
REQ-026 When the gap counter reaches TIMEOUT, the FSM SHALL set TimeoutErr and return to IDLE.
REQ-027 Words already queued after a timeout SHALL remain in the FIFO and drain normally; no Last marker is synthesized.
REQ-028 ClearErr SHALL clear all four sticky flags; an error event in the same cycle SHALL take priority and the flag remains set.
REQ-029 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from an occupancy count of width log2(DEPTH)+1.

Reset
REQ-030 Reset SHALL force: state IDLE, Remaining 0, gap counter 0, FIFO empty (pointers and count 0), WordValid 0, WordOut 16'h0000, First 0, Last 0, Busy 0, all error flags 0.
REQ-031 Reset asserted mid-packet SHALL discard the partial packet and all FIFO contents.

Structure
REQ-032 The state encoding, SYNC default, and header field positions (sync [15:12], length [3:0]) SHALL live in a shared package.
REQ-033 The FIFO SHALL be a separate sub-module, rx_word_fifo (18-bit wide: data + First + Last), instantiated once.

Verification
REQ-034 Header 16'hA003, then payload words 1111/2222/3333 with Ready=1 -> three WordValid cycles; First on 1111 only, Last on 3333 only; Busy falls on the 3333 push cycle.
REQ-035 Header 16'h5003 -> SyncErr=1, no FIFO push; a following valid header 16'hA001 + word 00AA -> single word delivered with First=Last=1.
REQ-036 Ready=0, header 16'hA006 + six words, DEPTH=4 -> first four words retained, Overflow=1, FSM returns to IDLE after the sixth word; ClearErr -> Overflow=0.
REQ-037 Header 16'hA004, two words, then silence for TIMEOUT cycles -> TimeoutErr=1, FSM IDLE, two queued words drain with Last=0.
REQ-038 Reset pulse asserted after the second payload word of 16'hA004 -> all outputs at reset values immediately, without waiting for a clock edge; a subsequent payload word is treated as a header (SyncErr if mismatched).

Source files
------------

// File: rtl/serial_rx_controller_pkg.sv
// Shared definitions for the serial receive controller: FSM states,
// header field positions and the default sync nibble.
package serial_rx_controller_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } rx_state_t;

    localparam logic [3:0]  SYNC_DEFAULT  = 4'hA;
    localparam int unsigned WORD_W        = 16;
    localparam int unsigned FIFO_W        = WORD_W + 2;
    localparam int unsigned HDR_SYNC_MSB  = 15;
    localparam int unsigned HDR_SYNC_LSB  = 12;
    localparam int unsigned HDR_LEN_MSB   = 3;
    localparam int unsigned HDR_LEN_LSB   = 0;

    function automatic logic [3:0] hdr_sync(input logic [WORD_W-1:0] w);
        return w[HDR_SYNC_MSB:HDR_SYNC_LSB];
    endfunction

    function automatic logic [3:0] hdr_len(input logic [WORD_W-1:0] w);
        return w[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage

// File: rtl/serial_rx_controller_fifo.sv
// Word FIFO holding {data, First, Last}; occupancy-count based full/empty,
// output forced to zero while empty.
module rx_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 18
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_valid,
    output logic             o_full,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && o_valid;
    // A push into a full FIFO is still taken when a pop frees a slot this cycle.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_rdata = o_valid ? r_mem[r_rd_ptr] : '0;

    // Storage array; contents are don't-care while not counted as occupied.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/serial_rx_controller.sv
// Serial receive controller: parses header words, frames payload words
// into the word FIFO with First/Last markers, and tracks sticky errors.
module serial_rx_controller
    import serial_rx_controller_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 2000,
    parameter logic [3:0]  SYNC    = SYNC_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              RxValid,
    input  logic [WORD_W-1:0] RxData,
    input  logic              Ready,
    input  logic              ClearErr,
    output logic              WordValid,
    output logic [WORD_W-1:0] WordOut,
    output logic              First,
    output logic              Last,
    output logic              Busy,
    output logic              Overflow,
    output logic              SyncErr,
    output logic              LenErr,
    output logic              TimeoutErr
);

    rx_state_t         r_state;
    rx_state_t         w_state_next;
    logic [3:0]        r_remaining;
    logic [15:0]       r_gap;
    logic              r_first;
    logic              w_load;
    logic              w_push;
    logic              w_last;
    logic              w_sync_ev;
    logic              w_len_ev;
    logic              w_to_ev;
    logic              w_ovf_ev;
    logic              w_pop;
    logic              w_full;
    logic [FIFO_W-1:0] w_rdata;

    assign w_pop    = WordValid && Ready;
    assign w_ovf_ev = w_push && w_full && !w_pop;
    assign Busy     = (r_state == ST_PAYLOAD);
    assign WordOut  = w_rdata[FIFO_W-1:2];
    assign First    = w_rdata[1];
    assign Last     = w_rdata[0];

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode: header parsing in IDLE, word framing and gap timeout in PAYLOAD.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_push       = 1'b0;
        w_last       = 1'b0;
        w_sync_ev    = 1'b0;
        w_len_ev     = 1'b0;
        w_to_ev      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (RxValid) begin
                    if (hdr_sync(RxData) != SYNC) begin
                        w_sync_ev = 1'b1;
                    end else if (hdr_len(RxData) == 4'd0) begin
                        w_len_ev = 1'b1;
                    end else begin
                        w_load       = 1'b1;
                        w_state_next = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (RxValid) begin
                    w_push = 1'b1;
                    w_last = (r_remaining == 4'd1);
                    if (w_last) w_state_next = ST_IDLE;
                end else if (r_gap == 16'(TIMEOUT)) begin
                    w_to_ev      = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Packet bookkeeping: remaining count, first-word marker and inter-word gap.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_gap       <= '0;
        end else begin
            if (w_load) begin
                r_remaining <= hdr_len(RxData);
                r_first     <= 1'b1;
            end else if (w_push) begin
                r_remaining <= r_remaining - 4'd1;
                r_first     <= 1'b0;
            end else if (w_to_ev) begin
                r_remaining <= '0;
                r_first     <= 1'b0;
            end
            if ((r_state == ST_PAYLOAD) && !RxValid && !w_to_ev) r_gap <= r_gap + 16'd1;
            else                                                 r_gap <= '0;
        end
    end

    // Sticky error flags; a same-cycle event wins over ClearErr.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Overflow   <= 1'b0;
            SyncErr    <= 1'b0;
            LenErr     <= 1'b0;
            TimeoutErr <= 1'b0;
        end else begin
            Overflow   <= w_ovf_ev  | (Overflow   & ~ClearErr);
            SyncErr    <= w_sync_ev | (SyncErr    & ~ClearErr);
            LenErr     <= w_len_ev  | (LenErr     & ~ClearErr);
            TimeoutErr <= w_to_ev   | (TimeoutErr & ~ClearErr);
        end
    end

    rx_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_push  (w_push),
        .i_wdata ({RxData, r_first, w_last}),
        .i_pop   (Ready),
        .o_valid (WordValid),
        .o_full  (w_full),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_serial_rx_controller.sv
// Bench for serial_rx_controller: queue-level behavioural model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_serial_rx_controller;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 20;
    localparam logic [3:0]  SYNC    = 4'hA;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        RxValid;
    logic [15:0] RxData;
    logic        Ready;
    logic        ClearErr;
    logic        WordValid;
    logic [15:0] WordOut;
    logic        First;
    logic        Last;
    logic        Busy;
    logic        Overflow;
    logic        SyncErr;
    logic        LenErr;
    logic        TimeoutErr;

    serial_rx_controller #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .SYNC    (SYNC)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .RxValid    (RxValid),
        .RxData     (RxData),
        .Ready      (Ready),
        .ClearErr   (ClearErr),
        .WordValid  (WordValid),
        .WordOut    (WordOut),
        .First      (First),
        .Last       (Last),
        .Busy       (Busy),
        .Overflow   (Overflow),
        .SyncErr    (SyncErr),
        .LenErr     (LenErr),
        .TimeoutErr (TimeoutErr)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [17:0] mq[$];
    bit          m_in_pkt;
    int          m_rem;
    bit          m_first;
    int          m_gap;
    bit          m_ovf, m_sync, m_len, m_to;

    task automatic model_step();
        int sz;
        bit pop, e_ovf, e_sync, e_len, e_to;
        sz = mq.size();
        pop = (sz > 0) && Ready;
        e_ovf = 0; e_sync = 0; e_len = 0; e_to = 0;
        if (pop) void'(mq.pop_front());
        if (!m_in_pkt) begin
            if (RxValid) begin
                if (RxData[15:12] != SYNC)   e_sync = 1;
                else if (RxData[3:0] == 0)   e_len = 1;
                else begin
                    m_in_pkt = 1; m_rem = int'(RxData[3:0]); m_first = 1; m_gap = 0;
                end
            end
        end else if (RxValid) begin
            if (sz == DEPTH && !pop) e_ovf = 1;
            else mq.push_back({RxData, m_first, (m_rem == 1)});
            m_first = 0;
            m_rem--;
            m_gap = 0;
            if (m_rem == 0) m_in_pkt = 0;
        end else if (m_gap == TIMEOUT) begin
            e_to = 1; m_in_pkt = 0; m_gap = 0;
        end else begin
            m_gap++;
        end
        m_ovf  = e_ovf  | (m_ovf  & !ClearErr);
        m_sync = e_sync | (m_sync & !ClearErr);
        m_len  = e_len  | (m_len  & !ClearErr);
        m_to   = e_to   | (m_to   & !ClearErr);
    endtask

    initial begin
        forever begin
            @(posedge Clock or posedge Reset);
            if (Reset) begin
                mq.delete();
                m_in_pkt = 0; m_rem = 0; m_first = 0; m_gap = 0;
                m_ovf = 0; m_sync = 0; m_len = 0; m_to = 0;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge Clock);
            e = (mq.size() != 0) ? mq[0] : 18'h0;
            chk1("m_valid", WordValid, mq.size() != 0);
            chkv("m_word", 32'(WordOut), 32'(e[17:2]));
            chk1("m_first", First, e[1]);
            chk1("m_last", Last, e[0]);
            chk1("m_busy", Busy, m_in_pkt);
            chk1("m_ovf", Overflow, m_ovf);
            chk1("m_sync", SyncErr, m_sync);
            chk1("m_len", LenErr, m_len);
            chk1("m_to", TimeoutErr, m_to);
        end
    end

    // Record every word actually handed to the consumer.
    logic [17:0] dq[$];
    initial begin
        forever begin
            @(negedge Clock);
            if (WordValid && Ready && !Reset) dq.push_back({WordOut, First, Last});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        RxValid = 1'b1;
        RxData  = w;
        tick();
        RxValid = 1'b0;
        RxData  = '0;
    endtask

    task automatic clear_err();
        ClearErr = 1'b1;
        tick();
        ClearErr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        Ready = 1'b1;
        while (WordValid && n < 50) begin
            tick();
            n++;
        end
        chk1("drain_bound", WordValid, 1'b0);
    endtask

    task automatic chk_dq(input string name, input int idx, input logic [17:0] exp);
        logic [17:0] act;
        act = (idx < dq.size()) ? dq[idx] : 18'h3FFFF;
        chkv(name, 32'(act), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        Reset = 1'b1; RxValid = 1'b0; RxData = '0; Ready = 1'b0; ClearErr = 1'b0;
        #3;
        chk1("rst_valid", WordValid, 1'b0);
        chkv("rst_word", 32'(WordOut), 32'h0);
        chk1("rst_busy", Busy, 1'b0);
        chkv("rst_flags", 32'({Overflow, SyncErr, LenErr, TimeoutErr}), 32'h0);
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        tick();

        // Basic three-word packet
        Ready = 1'b1; dq.delete();
        send(16'hA003);
        chk1("s1_busy_hdr", Busy, 1'b1);
        send(16'h1111);
        send(16'h2222);
        chk1("s1_busy_mid", Busy, 1'b1);
        send(16'h3333);
        chk1("s1_busy_fall", Busy, 1'b0);
        drain();
        chkv("s1_count", 32'(dq.size()), 32'd3);
        chk_dq("s1_w0", 0, {16'h1111, 1'b1, 1'b0});
        chk_dq("s1_w1", 1, {16'h2222, 1'b0, 1'b0});
        chk_dq("s1_w2", 2, {16'h3333, 1'b0, 1'b1});

        // Sync mismatch, then single-word packet
        dq.delete();
        send(16'h5003);
        chk1("s2_syncerr", SyncErr, 1'b1);
        chk1("s2_nopush", WordValid, 1'b0);
        send(16'hA001);
        send(16'h00AA);
        drain();
        chkv("s2_count", 32'(dq.size()), 32'd1);
        chk_dq("s2_w0", 0, {16'h00AA, 1'b1, 1'b1});
        clear_err();
        chk1("s2_clear", SyncErr, 1'b0);

        // Zero length header, then clear colliding with a new sync error
        send(16'hA000);
        chk1("s2_lenerr", LenErr, 1'b1);
        chk1("s2_len_idle", Busy, 1'b0);
        RxValid = 1'b1; RxData = 16'h5000; ClearErr = 1'b1;
        tick();
        RxValid = 1'b0; ClearErr = 1'b0;
        chk1("s2_clr_prio", SyncErr, 1'b1);
        chk1("s2_clr_len", LenErr, 1'b0);
        clear_err();

        // Overflow with consumer stalled
        Ready = 1'b0; dq.delete();
        send(16'hA006);
        for (int i = 1; i <= 6; i++) send(16'h0100 + 16'(i));
        chk1("s3_ovf", Overflow, 1'b1);
        chk1("s3_idle", Busy, 1'b0);
        chk1("s3_valid", WordValid, 1'b1);
        clear_err();
        chk1("s3_ovf_clr", Overflow, 1'b0);
        drain();
        chkv("s3_count", 32'(dq.size()), 32'd4);
        chk_dq("s3_w0", 0, {16'h0101, 1'b1, 1'b0});
        chk_dq("s3_w3", 3, {16'h0104, 1'b0, 1'b0});

        // Push into full FIFO with simultaneous pop is accepted
        Ready = 1'b0; dq.delete();
        send(16'hA006);
        for (int i = 1; i <= 4; i++) send(16'h0200 + 16'(i));
        Ready = 1'b1;
        send(16'h0205);
        send(16'h0206);
        chk1("s4_no_ovf", Overflow, 1'b0);
        drain();
        chkv("s4_count", 32'(dq.size()), 32'd6);
        chk_dq("s4_w4", 4, {16'h0205, 1'b0, 1'b0});
        chk_dq("s4_w5", 5, {16'h0206, 1'b0, 1'b1});

        // Inter-word timeout
        Ready = 1'b0; dq.delete();
        send(16'hA004);
        send(16'h0301);
        send(16'h0302);
        repeat (TIMEOUT) tick();
        chk1("s5_to_early", TimeoutErr, 1'b0);
        chk1("s5_busy_early", Busy, 1'b1);
        tick();
        chk1("s5_to", TimeoutErr, 1'b1);
        chk1("s5_idle", Busy, 1'b0);
        drain();
        chkv("s5_count", 32'(dq.size()), 32'd2);
        chk_dq("s5_w0", 0, {16'h0301, 1'b1, 1'b0});
        chk_dq("s5_w1", 1, {16'h0302, 1'b0, 1'b0});
        clear_err();
        chk1("s5_clr", TimeoutErr, 1'b0);

        // Asynchronous reset mid-packet
        Ready = 1'b0; dq.delete();
        send(16'hA004);
        send(16'h0401);
        send(16'h0402);
        chk1("s6_pre_valid", WordValid, 1'b1);
        chk1("s6_pre_first", First, 1'b1);
        Reset = 1'b1;
        #1;
        chk1("s6_rst_valid", WordValid, 1'b0);
        chkv("s6_rst_word", 32'(WordOut), 32'h0);
        chk1("s6_rst_first", First, 1'b0);
        chk1("s6_rst_busy", Busy, 1'b0);
        tick();
        Reset = 1'b0;
        tick();
        send(16'h0403);
        chk1("s6_as_header", SyncErr, 1'b1);
        chk1("s6_no_pkt", Busy, 1'b0);
        chk1("s6_empty", WordValid, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
